// File: rtl/reg_file_sb.sv
// Parametrised register file with N combinational read ports, one write port,
// optional x0 hardwiring, optional same-cycle write forwarding and a busy scoreboard.
module reg_file_sb #(
   parameter int unsigned ADDRESS_WIDTH  = 5,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned NUM_READ_PORTS = 2,
   parameter int unsigned BYPASS         = 1,
   parameter int unsigned ZERO_REG       = 1
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NUM_READ_PORTS*ADDRESS_WIDTH-1:0]  A,
   output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]     RD,
   output logic [NUM_READ_PORTS-1:0]                BUSY,
   input  logic [ADDRESS_WIDTH-1:0]                 A3,
   input  logic                                     WE3,
   input  logic [DATA_WIDTH-1:0]                    WD3,
   input  logic                                     SB_SET,
   input  logic [ADDRESS_WIDTH-1:0]                 SB_A,
   output logic [ADDRESS_WIDTH:0]                   BUSY_CNT
);

   localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
   localparam int unsigned CNT_W = ADDRESS_WIDTH + 1;
   localparam logic        ZR    = (ZERO_REG != 0);
   localparam logic        BP    = (BYPASS != 0);

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0]      busy;
   logic [DEPTH-1:0]      busy_nxt;
   logic [CNT_W-1:0]      cnt_nxt;
   logic                  wr_ok;
   logic                  set_ok;

   assign wr_ok  = WE3 & ~(ZR & (A3 == '0));
   assign set_ok = SB_SET & ~(ZR & (SB_A == '0));

   // Clear is applied before set so a same-address issue and writeback leaves the bit set.
   always_comb begin
      busy_nxt = busy;
      if (WE3) begin
         busy_nxt[A3] = 1'b0;
      end
      if (set_ok) begin
         busy_nxt[SB_A] = 1'b1;
      end
   end

   always_comb begin
      cnt_nxt = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[k]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= '0;
         BUSY_CNT <= '0;
      end else begin
         busy     <= busy_nxt;
         BUSY_CNT <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            regs[k] <= '0;
         end
      end else if (wr_ok) begin
         regs[A3] <= WD3;
      end
   end

   for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : g_rd
      logic [ADDRESS_WIDTH-1:0] ra;
      logic                     is_zero;
      logic                     fwd;
      logic [DATA_WIDTH-1:0]    rd_i;
      logic                     busy_i;

      assign ra = A[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];

      // A forwarded write also masks the stall: its data is already on RD.
      always_comb begin
         is_zero = ZR & (ra == '0);
         fwd     = BP & WE3 & (A3 == ra) & ~is_zero;
         if (is_zero) begin
            rd_i = '0;
         end else if (fwd) begin
            rd_i = WD3;
         end else begin
            rd_i = regs[ra];
         end
         busy_i = ~is_zero & busy[ra] & ~fwd;
      end

      assign RD[i*DATA_WIDTH +: DATA_WIDTH] = rd_i;
      assign BUSY[i]                        = busy_i;
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a forwarding 32-bit/2-port instance and a non-forwarding
// 64-bit/4-port instance share one write/scoreboard stream against an array model.
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  a_0;
   logic [19:0] a_1;
   logic [63:0] rd_0;
   logic [255:0] rd_1;
   logic [1:0]  busy_0;
   logic [3:0]  busy_1;
   logic [5:0]  cnt_0;
   logic [5:0]  cnt_1;
   logic [4:0]  a3;
   logic        we3;
   logic [63:0] wd3;
   logic        sb_set;
   logic [4:0]  sb_a;

   int unsigned nchecks = 0;
   int unsigned nerrors = 0;

   logic [63:0] mreg  [32];
   logic        mbusy [32];

   always #5 clk = ~clk;

   reg_file_sb #(
      .ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_READ_PORTS(2), .BYPASS(1), .ZERO_REG(1)
   ) dut_byp (
      .clk(clk), .rst(rst), .A(a_0), .RD(rd_0), .BUSY(busy_0),
      .A3(a3), .WE3(we3), .WD3(wd3[31:0]), .SB_SET(sb_set), .SB_A(sb_a), .BUSY_CNT(cnt_0)
   );

   reg_file_sb #(
      .ADDRESS_WIDTH(5), .DATA_WIDTH(64), .NUM_READ_PORTS(4), .BYPASS(0), .ZERO_REG(1)
   ) dut_nob (
      .clk(clk), .rst(rst), .A(a_1), .RD(rd_1), .BUSY(busy_1),
      .A3(a3), .WE3(we3), .WD3(wd3), .SB_SET(sb_set), .SB_A(sb_a), .BUSY_CNT(cnt_1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerrors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_rd(input logic [4:0] ad, input logic byp);
      if (ad == 0) return 64'd0;
      if (byp && we3 && a3 == ad) return wd3;
      return mreg[ad];
   endfunction

   function automatic logic exp_busy(input logic [4:0] ad, input logic byp);
      if (ad == 0) return 1'b0;
      return mbusy[ad] && !(byp && we3 && a3 == ad);
   endfunction

   function automatic logic [63:0] model_count();
      logic [63:0] n = 0;
      for (int k = 1; k < 32; k++) n += 64'(mbusy[k]);
      return n;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 32; k++) begin
         mreg[k]  = 64'd0;
         mbusy[k] = 1'b0;
      end
   endtask

   task automatic model_update();
      if (we3 && a3 != 0) begin
         mreg[a3]  = wd3;
         mbusy[a3] = 1'b0;
      end
      if (sb_set && sb_a != 0) mbusy[sb_a] = 1'b1;
   endtask

   task automatic check_outputs();
      logic [4:0]  ad;
      logic [63:0] e;
      for (int p = 0; p < 2; p++) begin
         ad = a_0[p*5 +: 5];
         e  = exp_rd(ad, 1'b1);
         check($sformatf("rd_byp[%0d]@x%0d", p, ad), {32'd0, rd_0[p*32 +: 32]}, {32'd0, e[31:0]});
         check($sformatf("busy_byp[%0d]@x%0d", p, ad), 64'(busy_0[p]), 64'(exp_busy(ad, 1'b1)));
      end
      for (int p = 0; p < 4; p++) begin
         ad = a_1[p*5 +: 5];
         check($sformatf("rd_nob[%0d]@x%0d", p, ad), rd_1[p*64 +: 64], exp_rd(ad, 1'b0));
         check($sformatf("busy_nob[%0d]@x%0d", p, ad), 64'(busy_1[p]), 64'(exp_busy(ad, 1'b0)));
      end
      check("cnt_byp", 64'(cnt_0), model_count());
      check("cnt_nob", 64'(cnt_1), model_count());
   endtask

   task automatic idle();
      we3 = 1'b0; a3 = '0; wd3 = '0; sb_set = 1'b0; sb_a = '0;
   endtask

   task automatic set_reads(input logic [4:0] ad);
      a_0 = {2{ad}};
      a_1 = {4{ad}};
   endtask

   // Inputs are driven just after a falling edge; outputs checked 1 time unit later.
   task automatic cycle();
      #1 check_outputs();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle();
      set_reads(5'd5);
      model_reset();
      repeat (2) @(negedge clk);
      #1 check_outputs();
      check("reset_cnt", 64'(cnt_0), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Reset pulse mid-run clears state without a clock edge.
      we3 = 1'b1; a3 = 5'd5; wd3 = 64'hDEADBEEF; sb_set = 1'b1; sb_a = 5'd6;
      cycle();
      idle();
      check("x5_written", {32'd0, rd_0[31:0]}, 64'hDEADBEEF);
      rst = 1'b1;
      #1 model_reset();
      check("rst_x5_byp", {32'd0, rd_0[31:0]}, 64'd0);
      check("rst_x5_nob", rd_1[63:0], 64'd0);
      check("rst_cnt", 64'(cnt_0), 64'd0);
      check_outputs();
      #1 rst = 1'b0;
      @(negedge clk);

      // Zero register ignores writes and scoreboard sets.
      set_reads(5'd0);
      we3 = 1'b1; a3 = 5'd0; wd3 = 64'h1234; sb_set = 1'b1; sb_a = 5'd0;
      cycle();
      idle();
      cycle();
      check("x0_read", {32'd0, rd_0[31:0]}, 64'd0);
      check("x0_cnt", 64'(cnt_0), 64'd0);

      // Forwarding on one instance, delayed visibility on the other.
      set_reads(5'd7);
      we3 = 1'b1; a3 = 5'd7; wd3 = 64'h11112222CAFEF00D;
      #1 check("byp_p0", {32'd0, rd_0[31:0]}, 64'hCAFEF00D);
      check("byp_p1", {32'd0, rd_0[63:32]}, 64'hCAFEF00D);
      check("nob_old", rd_1[63:0], 64'd0);
      cycle();
      idle();
      #1 check("nob_new", rd_1[191:128], 64'h11112222CAFEF00D);
      cycle();

      // Issue then writeback of x3.
      set_reads(5'd3);
      sb_set = 1'b1; sb_a = 5'd3;
      cycle();
      idle();
      check("busy3_set", 64'(busy_0[0]), 64'd1);
      check("cnt_one", 64'(cnt_0), 64'd1);
      we3 = 1'b1; a3 = 5'd3; wd3 = 64'h77;
      #1 check("busy3_fwd", 64'(busy_0[1]), 64'd0);
      check("busy3_nob", 64'(busy_1[2]), 64'd1);
      cycle();
      idle();
      check("cnt_zero", 64'(cnt_0), 64'd0);

      // Same-edge set and clear.
      a_0 = {5'd4, 5'd9}; a_1 = {5'd4, 5'd9, 5'd4, 5'd9};
      we3 = 1'b1; a3 = 5'd9; wd3 = 64'h55; sb_set = 1'b1; sb_a = 5'd9;
      cycle();
      idle();
      check("x9_data", rd_1[63:0], 64'h55);
      check("x9_busy", 64'(busy_1[0]), 64'd1);
      sb_set = 1'b1; sb_a = 5'd4;
      cycle();
      we3 = 1'b1; a3 = 5'd4; wd3 = 64'hABC; sb_set = 1'b1; sb_a = 5'd9;
      cycle();
      idle();
      cycle();
      check("x4_cleared", 64'(busy_1[1]), 64'd0);

      // Fill and drain the whole scoreboard.
      for (int r = 1; r < 32; r++) begin
         set_reads(5'(r));
         sb_set = 1'b1; sb_a = 5'(r);
         cycle();
      end
      idle();
      cycle();
      check("cnt_full", 64'(cnt_1), 64'd31);
      for (int r = 1; r < 32; r++) begin
         set_reads(5'(r));
         we3 = 1'b1; a3 = 5'(r); wd3 = {$urandom, $urandom};
         cycle();
         check("cnt_drain", 64'(cnt_0), 64'(31 - r));
      end
      idle();
      cycle();

      // Randomized traffic, addresses biased toward the write/issue targets.
      for (int n = 0; n < 400; n++) begin
         we3 = 1'($urandom_range(0, 1)); a3 = 5'($urandom);
         wd3 = {$urandom, $urandom};
         sb_set = 1'($urandom_range(0, 2) == 0); sb_a = 5'($urandom);
         for (int p = 0; p < 2; p++)
            a_0[p*5 +: 5] = ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom);
         for (int p = 0; p < 4; p++)
            a_1[p*5 +: 5] = ($urandom_range(0, 2) == 0) ? sb_a : 5'($urandom);
         cycle();
      end
      idle();
      cycle();

      $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
      $finish;
   end

endmodule
